// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external combinational ALU between two requesters
//   (0 = integer datapath, 1 = address/branch unit). Arbitration is round-robin.
//   Requests use a valid/ready handshake. Operands and results are registered.
//   Each requester gets its own response handshake.
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid/req_ready[1:0] request handshake, one bit per requester
//   req{0,1}_a/_b/_op        per-requester operands and ALU opcode
//   alu_a/alu_b/alu_ctrl     operand registers driven to the external ALU
//   alu_result/alu_zero      results returned by the external ALU
//   rsp_valid/rsp_ready[1:0] response handshake; rsp_valid is one-hot on the granted requester
//   rsp_result/rsp_zero      registered ALU result and Zero flag
//   rsp_err                  opcode was not AND/OR/ADD/SUB/SLT
//   busy                     an operation is in flight
module alu_share_arbiter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_op,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_op,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               gid_q, gid_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CTRL_W-1:0]  op_q, op_d;
  logic               zero_q, zero_d, err_q, err_d;
  logic               grant_valid, grant_id;
  logic               op_illegal;

  // Round-robin choice: the pointer side wins, otherwise the other side.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ptr_q;
    if (req_valid[ptr_q]) begin
      grant_valid = 1'b1;
      grant_id    = ptr_q;
    end else if (req_valid[~ptr_q]) begin
      grant_valid = 1'b1;
      grant_id    = ~ptr_q;
    end
  end

  always_comb begin
    case (op_q)
      CTRL_W'(4'b0000), CTRL_W'(4'b0001), CTRL_W'(4'b0010),
      CTRL_W'(4'b0110), CTRL_W'(4'b0111): op_illegal = 1'b0;
      default:                            op_illegal = 1'b1;
    endcase
  end

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      gid_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and datapath next values
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = EXEC;
          gid_d   = grant_id;
          a_d     = grant_id ? req1_a  : req0_a;
          b_d     = grant_id ? req1_b  : req0_b;
          op_d    = grant_id ? req1_op : req0_op;
        end
      end
      EXEC: begin
        state_d = RESP;
        // An illegal opcode still reaches the ALU, but its output is replaced here.
        res_d   = op_illegal ? '0   : alu_result;
        zero_d  = op_illegal ? 1'b1 : alu_zero;
        err_d   = op_illegal;
      end
      RESP: begin
        if (rsp_ready[gid_q]) begin
          state_d = IDLE;
          ptr_d   = ~gid_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == IDLE && grant_valid) req_ready[grant_id] = 1'b1;
    if (state_q == RESP)                rsp_valid[gid_q]    = 1'b1;
  end

  assign busy       = (state_q != IDLE);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ctrl   = op_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_result, rsp_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero, rsp_zero, rsp_err, busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy)
  );

  // Model of the external ALU; an unknown opcode returns a recognisable nonzero value.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    #3;
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_rsp_result", rsp_result, 0);
    #4 rst_n = 1'b1;
    step();

    // Single op: req0 ADD 10+5
    req0_a = 10; req0_b = 5; req0_op = 4'b0010; req_valid = 2'b01;
    #1 chk("single_req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    chk("single_exec_busy", busy, 1);
    chk("single_exec_rsp_valid", rsp_valid, 0);
    chk("single_alu_a", alu_a, 10);
    chk("single_alu_ctrl", alu_ctrl, 4'b0010);
    step();
    chk("single_rsp_valid", rsp_valid, 2'b01);
    chk("single_result", rsp_result, 15);
    chk("single_zero", rsp_zero, 0);
    chk("single_err", rsp_err, 0);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    chk("single_done_valid", rsp_valid, 0);
    chk("single_done_busy", busy, 0);

    // Reset mid-EXEC (pointer is now 1, so req1 is granted first here)
    req1_a = 1; req1_b = 2; req1_op = 4'b0010; req_valid = 2'b10;
    #1 chk("rst_req_ready", req_ready, 2'b10);
    step();
    chk("rst_in_exec", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_busy", busy, 0);
    chk("rst_async_rsp_valid", rsp_valid, 0);
    chk("rst_async_alu_a", alu_a, 0);
    chk("rst_async_result", rsp_result, 0);
    req_valid = 2'b00;
    #2 rst_n = 1'b1;
    step();
    chk("rst_no_rsp", rsp_valid, 0);
    chk("rst_idle", busy, 0);

    // Contention with both held: grants 0,1,0,1 from reset pointer
    req0_a = 10; req0_b = 5; req0_op = 4'b0110;
    req1_a = 10; req1_b = 5; req1_op = 4'b0000;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("cont%0d_req_ready", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
      chk($sformatf("cont%0d_exec_ready", i), req_ready, 0);
      step();
      chk($sformatf("cont%0d_rsp_valid", i), rsp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("cont%0d_result", i), rsp_result, (i % 2 == 0) ? 5 : 0);
      chk($sformatf("cont%0d_zero", i), rsp_zero, (i % 2 == 0) ? 0 : 1);
      step();
    end
    req_valid = 2'b00; rsp_ready = 2'b00;

    // Backpressure: req1 OR 10|5 held 5 cycles; rsp_ready[0] ignored; req0 waits
    req1_a = 10; req1_b = 5; req1_op = 4'b0001; req_valid = 2'b10;
    #1 chk("bp_req_ready", req_ready, 2'b10);
    step();
    req0_a = 7; req0_b = 3; req0_op = 4'b0010; req_valid = 2'b01; rsp_ready = 2'b01;
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_rsp_valid", i), rsp_valid, 2'b10);
      chk($sformatf("bp%0d_result", i), rsp_result, 15);
      chk($sformatf("bp%0d_req_ready", i), req_ready, 0);
      step();
    end
    rsp_ready = 2'b10;
    #1 chk("bp_release_valid", rsp_valid, 2'b10);
    step();
    chk("bp_after_valid", rsp_valid, 0);
    chk("bp_after_busy", busy, 0);
    chk("bp_waiter_granted", req_ready, 2'b01);
    rsp_ready = 2'b11;
    step();
    req_valid = 2'b00;
    step();
    chk("bp_waiter_rsp", rsp_valid, 2'b01);
    chk("bp_waiter_result", rsp_result, 10);
    step();

    // SLT 5<10 then illegal opcode (pointer is 1, only req0 valid)
    req0_a = 5; req0_b = 10; req0_op = 4'b0111; req_valid = 2'b01;
    #1 chk("slt_req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    step();
    chk("slt_result", rsp_result, 1);
    chk("slt_zero", rsp_zero, 0);
    chk("slt_err", rsp_err, 0);
    step();
    req0_op = 4'b1111; req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    chk("ill_alu_ctrl", alu_ctrl, 4'b1111);
    step();
    chk("ill_rsp_valid", rsp_valid, 2'b01);
    chk("ill_result", rsp_result, 0);
    chk("ill_zero", rsp_zero, 1);
    chk("ill_err", rsp_err, 1);
    step();

    // Back-to-back: req1 held, rsp_ready tied high -> accept every 3 cycles
    req1_a = 1; req1_b = 2; req1_op = 4'b0010; req_valid = 2'b10; rsp_ready = 2'b11;
    #1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("b2b%0d_req_ready", i), req_ready, (i % 3 == 0) ? 2'b10 : 2'b00);
      chk($sformatf("b2b%0d_rsp_valid", i), rsp_valid, (i % 3 == 2) ? 2'b10 : 2'b00);
      if (i % 3 == 2) chk($sformatf("b2b%0d_result", i), rsp_result, 3);
      step();
    end
    req_valid = 2'b00;
    #1;
    chk("b2b_end_busy", busy, 0);
    chk("b2b_end_req_ready", req_ready, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
